// File: rtl/adia_seq_pkg.sv
// Shared types for the adiabatic operand sequencer: power-clock phase
// encoding, sequencer FSM states and the phase-counter width helper.
package adia_seq_pkg;

    typedef enum logic [1:0] {
        PH_OFF  = 2'b00,
        PH_RISE = 2'b01,
        PH_HIGH = 2'b10,
        PH_FALL = 2'b11
    } phase_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP0,
        S_UP1,
        S_EVAL,
        S_DN1,
        S_DN0
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adia_op_sequencer_if.sv
// Operand-in and result-out valid/ready handshakes of the sequencer.
// master = upstream/downstream environment, slave = the sequencer.
interface adia_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/adia_phase_timer.sv
// Phase dwell counter: counts 0..PHASE_CYCLES-1, wraps on terminal count.
// Latency: tc_o is a decode of the registered count (same-cycle).
// Backpressure: frz_i holds the count; clr_i (higher priority) forces 0.
module adia_phase_timer
    import adia_seq_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic frz_i,
    output logic tc_o
);
    localparam int            CW   = cnt_w(PHASE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!frz_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/adia_op_sequencer.sv
// Sequences one adiabatic AND evaluation: load operands, ramp power clocks, sample, ramp down.
// Latency: LOAD 1 cycle + 5 phases of PHASE_CYCLES; result registered on last EVAL cycle.
// Backpressure: a full result buffer holds EVAL (HIGH/HIGH) until drained. Optional ADIA_SEQ_CHECK_EN.
module adia_op_sequencer
    import adia_seq_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int PHASE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adia_op_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [1:0]           phase0,
    output logic [1:0]           phase1,
    input  logic [WIDTH-1:0]     eval_data,
    output logic                 err
);
    state_e           state_q, state_d;
    phase_e           ph0, ph1;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             take, tc, stall, sample, tmr_clr, tmr_frz;

    assign take   = bus.in_valid && (state_q == S_IDLE);
    assign stall  = res_valid_q && !bus.res_ready;
    assign sample = (state_q == S_EVAL) && tc && !stall;

    always_comb begin
        state_d = state_q;
        ph0     = PH_OFF;
        ph1     = PH_OFF;
        unique case (state_q)
            S_IDLE: if (take) state_d = S_LOAD;
            S_LOAD: state_d = S_UP0;
            S_UP0: begin
                ph0 = PH_RISE;
                if (tc) state_d = S_UP1;
            end
            S_UP1: begin
                ph0 = PH_HIGH;
                ph1 = PH_RISE;
                if (tc) state_d = S_EVAL;
            end
            S_EVAL: begin
                ph0 = PH_HIGH;
                ph1 = PH_HIGH;
                if (sample) state_d = S_DN1;
            end
            S_DN1: begin
                ph0 = PH_HIGH;
                ph1 = PH_FALL;
                if (tc) state_d = S_DN0;
            end
            S_DN0: begin
                ph0 = PH_FALL;
                if (tc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Freeze only at terminal count: a pending result earlier in EVAL must not stop the dwell.
    assign tmr_clr = (state_d != state_q) || (state_q inside {S_IDLE, S_LOAD});
    assign tmr_frz = (state_q == S_EVAL) && tc && stall;

    adia_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .frz_i (tmr_frz),
        .tc_o  (tc)
    );

    always_comb begin
        op_a_d      = take   ? bus.in_a  : op_a_q;
        op_b_d      = take   ? bus.in_b  : op_b_q;
        res_data_d  = sample ? eval_data : res_data_q;
        res_valid_d = sample || (res_valid_q && !bus.res_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef ADIA_SEQ_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (sample && (eval_data != (op_a_q & op_b_q))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign phase0        = ph0;
    assign phase1        = ph1;

endmodule

// File: tb/tb_adia_op_sequencer.sv
// Random-operand bench for adia_op_sequencer: PHASE_CYCLES=4 instance for timing,
// stall, reset and checker cases; PHASE_CYCLES=1 instance for back-to-back throughput.
module tb_adia_op_sequencer;
    localparam int P4 = 4;
    localparam int P1 = 1;
`ifdef ADIA_SEQ_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adia_op_sequencer_if #(.WIDTH(16)) b4 ();
    adia_op_sequencer_if #(.WIDTH(16)) b1 ();

    logic [15:0] op_a4, op_b4, ed4, op_a1, op_b1, ed1;
    logic [1:0]  p0_4, p1_4, p0_1, p1_1;
    logic        err4, err1;
    logic        corrupt = 1'b0;

    // Downstream adiabatic AND stage; corrupt forces a wrong answer.
    assign ed4 = corrupt ? 16'h0000 : (op_a4 & op_b4);
    assign ed1 = op_a1 & op_b1;

    adia_op_sequencer #(.WIDTH(16), .PHASE_CYCLES(P4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave),
        .op_a(op_a4), .op_b(op_b4), .phase0(p0_4), .phase1(p1_4),
        .eval_data(ed4), .err(err4)
    );

    adia_op_sequencer #(.WIDTH(16), .PHASE_CYCLES(P1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave),
        .op_a(op_a1), .op_b(op_b1), .phase0(p0_1), .phase1(p1_1),
        .eval_data(ed1), .err(err1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {phase0,phase1} expected m cycles after the transfer edge (m=0 is LOAD).
    function automatic logic [3:0] exp_phase(input int m, input int p);
        if (m <= 0 || m > 5 * p) return 4'b0000;
        case ((m - 1) / p)
            0:       return 4'b0100;
            1:       return 4'b1001;
            2:       return 4'b1010;
            3:       return 4'b1011;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic wait_rdy4();
        int n = 0;
        while (!b4.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b4.in_ready) chk("rdy_timeout", 0, 1);
    endtask

    // One complete operation on dut4, checked cycle by cycle; result buffer must be empty at entry.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit inject, input bit bad, input bit rr);
        logic [15:0] exp_r;
        exp_r = bad ? 16'h0000 : (a & b);
        wait_rdy4();
        corrupt      = bad;
        b4.res_ready = rr;
        b4.in_valid  = 1'b1;
        b4.in_a      = a;
        b4.in_b      = b;
        @(posedge clk);
        for (int m = 0; m <= 5 * P4 + 1; m++) begin
            @(negedge clk);
            chk("phase", {p0_4, p1_4}, exp_phase(m, P4));
            chk("in_ready", b4.in_ready, (m == 5 * P4 + 1));
            chk("res_valid", b4.res_valid, rr ? (m == 3 * P4 + 1) : (m >= 3 * P4 + 1));
            chk("op_a", op_a4, a);
            chk("op_b", op_b4, b);
            if (m == 3 * P4 + 1) begin
                if (bad && CHECK_EN) exp_err = 1'b1;
                chk("res_data", b4.res_data, exp_r);
                chk("err", err4, exp_err);
            end
            b4.in_valid = inject && (m >= P4 + 1) && (m <= 2 * P4);
            b4.in_a     = 16'($urandom);
            b4.in_b     = 16'($urandom);
        end
        corrupt = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] xa, xb;
        logic [15:0] q1[$];
        int cyc, last_rv, got, npush;

        b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.res_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.res_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_phase4", {p0_4, p1_4}, 4'b0000);
        chk("rst_rv4", b4.res_valid, 0);
        chk("rst_rd4", b4.res_data, 0);
        chk("rst_op4", {op_a4, op_b4}, 0);
        chk("rst_err4", err4, 0);
        chk("rst_phase1", {p0_1, p1_1}, 4'b0000);
        chk("rst_rv1", b1.res_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy4", b4.in_ready, 1);
        chk("rst_rdy1", b1.in_ready, 1);

        // Directed AND, then a mid-operation in_valid injection, then random ops
        run_op(16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        run_op(16'hA5C3, 16'h3C3C, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

        // Faulty downstream stage; err sticky when the checker is built in
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in EVAL with a result still pending
        run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        wait_rdy4();
        b4.in_valid = 1'b1; b4.in_a = 16'h5555; b4.in_b = 16'hFFFF;
        @(posedge clk);
        for (int m = 0; m < 2 * P4 + 2; m++) begin
            @(negedge clk);
            b4.in_valid = 1'b0;
        end
        chk("pre_rst_phase", {p0_4, p1_4}, 4'b1010);
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("arst_phase", {p0_4, p1_4}, 4'b0000);
        chk("arst_rv", b4.res_valid, 0);
        chk("arst_rd", b4.res_data, 0);
        chk("arst_op", {op_a4, op_b4}, 0);
        chk("arst_err", err4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rdy", b4.in_ready, 1);
        chk("arst_rv_after", b4.res_valid, 0);
        run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);

        // EVAL stall behind an unconsumed result
        xa = 16'($urandom); xb = 16'($urandom);
        run_op(xa, xb, 1'b0, 1'b0, 1'b0);
        wait_rdy4();
        b4.in_valid = 1'b1; b4.in_a = 16'h1234; b4.in_b = 16'hFFFF;
        @(posedge clk);
        for (int m = 0; m <= 3 * P4; m++) begin
            @(negedge clk);
            b4.in_valid = 1'b0;
            chk("stl_phase", {p0_4, p1_4}, exp_phase(m, P4));
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stl_hold_phase", {p0_4, p1_4}, 4'b1010);
            chk("stl_hold_rdy", b4.in_ready, 0);
            chk("stl_hold_rv", b4.res_valid, 1);
            chk("stl_hold_data", b4.res_data, xa & xb);
        end
        b4.res_ready = 1'b1;
        @(negedge clk);
        chk("stl_new_rv", b4.res_valid, 1);
        chk("stl_new_data", b4.res_data, 16'h1234);
        chk("stl_dn1_phase", {p0_4, p1_4}, 4'b1011);
        @(negedge clk);
        chk("stl_drained", b4.res_valid, 0);
        wait_rdy4();
        run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);

        // PHASE_CYCLES=1 back-to-back: one result every 7 cycles
        cyc = 0; last_rv = -1; got = 0; npush = 0;
        while (got < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (b1.res_valid) begin
                if (q1.size() == 0) chk("b2b_unexpected", 1, 0);
                else chk("b2b_data", b1.res_data, q1.pop_front());
                if (last_rv >= 0) chk("b2b_period", cyc - last_rv, 7);
                last_rv = cyc;
                got++;
            end
            b1.in_valid = (npush < 20);
            b1.in_a     = 16'($urandom);
            b1.in_b     = 16'($urandom);
            if (b1.in_valid && b1.in_ready) begin
                q1.push_back(b1.in_a & b1.in_b);
                npush++;
            end
        end
        b1.in_valid = 1'b0;
        chk("b2b_count", got, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adia_op_sequencer.md
ADIA_OP_SEQUENCER -- requirements
Module: adia_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter PHASE_CYCLES, default 4, clock cycles per ramp/hold phase (legal >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  operand handshake.
REQ-006 SHALL have ports in_a, in_b  input  WIDTH  operands offered with in_valid.
REQ-007 SHALL have ports op_a, op_b  output  WIDTH  registered operands driven to the downstream adiabatic AND stage.
REQ-008 SHALL have ports phase0, phase1  output  2  encoded power-clock state per stage: OFF=00, RISE=01, HIGH=10, FALL=11.
REQ-009 SHALL have port eval_data  input  WIDTH  downstream stage output.
REQ-010 SHALL have ports res_valid output 1, res_ready input 1, res_data output WIDTH  result handshake.
REQ-011 SHALL have port err  output  1  sticky golden-model mismatch flag.

Function
REQ-012 SHALL step FSM IDLE -> LOAD -> UP0 -> UP1 -> EVAL -> DN1 -> DN0 -> IDLE.
REQ-013 SHALL assert in_ready only in IDLE; transfer occurs on in_valid && in_ready.
REQ-014 SHALL capture in_a/in_b into op_a/op_b on transfer; op_a/op_b held constant until next transfer.
REQ-015 SHALL spend exactly 1 cycle in LOAD and exactly PHASE_CYCLES cycles in each of UP0, UP1, EVAL, DN1, DN0, except EVAL stall (REQ-019).
REQ-016 SHALL drive phases per state: IDLE/LOAD OFF/OFF; UP0 RISE/OFF; UP1 HIGH/RISE; EVAL HIGH/HIGH; DN1 HIGH/FALL; DN0 FALL/OFF.
REQ-017 SHALL sample eval_data into res_data on the last EVAL cycle and set res_valid on that edge.
REQ-018 SHALL latency: with PHASE_CYCLES=4, transfer at edge k gives res_valid visible at cycle k+14 and in_ready high again at cycle k+22.
REQ-019 SHALL, if res_valid=1 and res_ready=0 on the last EVAL cycle, hold EVAL (phases HIGH/HIGH, counter frozen) until the result buffer empties, then sample.
REQ-020 SHALL clear res_valid on res_valid && res_ready; simultaneous clear and new sample SHALL leave res_valid=1 with new data.
REQ-021 SHALL ignore in_valid outside IDLE; in_a/in_b changes mid-operation SHALL not affect op_a/op_b.
REQ-022 SHALL wrap phase counter to 0 on every state change; PHASE_CYCLES=1 SHALL give one cycle per phase.

Reset
REQ-023 SHALL on rst_n=0 immediately force: state IDLE, counter 0, in_ready 1 after release, op_a/op_b 0, phase0/phase1 OFF, res_valid 0, res_data 0, err 0.
REQ-024 SHALL, on reset mid-operation, abort without completing ramp-down and discard any pending result.

Configuration
REQ-025 SHALL, with ADIA_SEQ_CHECK_EN defined, compare sampled eval_data against op_a & op_b and set err on mismatch, sticky until reset.
REQ-026 SHALL, without ADIA_SEQ_CHECK_EN, tie err to 0 and contain no comparator logic.

Structure
REQ-027 SHALL place phase encoding enum (OFF/RISE/HIGH/FALL) and FSM state enum in package adia_seq_pkg.
REQ-028 SHALL use one sub-module adia_phase_timer (PHASE_CYCLES counter with clear, freeze, terminal-count output).

Verification
REQ-029 SHALL check: reset, in_a=FFFF,in_b=0F0F, model returns AND -> res_data=0F0F at cycle k+14, err=0, phase sequence per REQ-016 with 4-cycle phases.
REQ-030 SHALL check: res_ready held 0 after first result, second op 1234/FFFF -> EVAL stalls HIGH/HIGH; raise res_ready -> first result consumed, res_data=1234 next.
REQ-031 SHALL check: in_valid high with new operands during UP1 -> ignored, op_a/op_b unchanged, in_ready=0.
REQ-032 SHALL check: rst_n pulsed low during EVAL -> phases OFF/OFF and res_valid=0 asynchronously, next op completes normally.
REQ-033 SHALL check (ADIA_SEQ_CHECK_EN): model forces eval_data=0000 for a=b=FFFF -> err=1 and stays 1; without macro err=0.
REQ-034 SHALL check: PHASE_CYCLES=1, back-to-back ops with res_ready=1 -> one result per 7 cycles, values correct.
